// File: rtl/hprb_arb2.sv
// hprb_arb2: two-input round-robin arbiter/sequencer for probe message channels.
//
// Accepts 4-phase req/ack messages from two probe sources and forwards them one
// at a time onto a single output channel. Each granted message is latched, the
// full output handshake is run, and only then is the granted input acked.
//
// Ports:
//   gch_clk, gch_reset      clock, asynchronous active-high reset
//   gch_ready               high from the first edge after reset release
//   rcv0_req/data/ack_out   input channel 0 (req asynchronous, data stable while req)
//   rcv1_req/data/ack_out   input channel 1
//   snd0_req_out/data/ack   output channel (ack asynchronous)
//   cnt0, cnt1              wrapping counts of messages forwarded per input
module hprb_arb2 #(
    parameter int unsigned ASZ    = 8,
    parameter int unsigned DSZ    = 16,
    parameter int unsigned RSZ    = 4,
    parameter int unsigned MSZ    = 2 * ASZ + DSZ + RSZ,
    parameter int unsigned CNT_SZ = 8
) (
    input  logic              gch_clk,
    input  logic              gch_reset,
    output logic              gch_ready,
    input  logic              rcv0_req,
    input  logic [MSZ-1:0]    rcv0_data,
    output logic              rcv0_ack_out,
    input  logic              rcv1_req,
    input  logic [MSZ-1:0]    rcv1_data,
    output logic              rcv1_ack_out,
    output logic              snd0_req_out,
    output logic [MSZ-1:0]    snd0_data,
    input  logic              snd0_ack,
    output logic [CNT_SZ-1:0] cnt0,
    output logic [CNT_SZ-1:0] cnt1
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDrain,
        StRelease
    } state_e;

    state_e state;
    logic   grant;       // input currently being served
    logic   last_grant;  // input served most recently; loses the next tie

    // Two-flop synchronisers for the asynchronous handshake inputs.
    logic req0_meta, req0_sync;
    logic req1_meta, req1_sync;
    logic ack_meta,  ack_sync;

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            req0_meta <= 1'b0;
            req0_sync <= 1'b0;
            req1_meta <= 1'b0;
            req1_sync <= 1'b0;
            ack_meta  <= 1'b0;
            ack_sync  <= 1'b0;
        end else begin
            req0_meta <= rcv0_req;
            req0_sync <= req0_meta;
            req1_meta <= rcv1_req;
            req1_sync <= req1_meta;
            ack_meta  <= snd0_ack;
            ack_sync  <= ack_meta;
        end
    end

    // Input 1 wins if it is the only requester, or on a tie when input 0 was served last.
    logic pick1;
    logic granted_req;

    always_comb begin
        pick1       = req1_sync && (!req0_sync || !last_grant);
        granted_req = grant ? req1_sync : req0_sync;
    end

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            state        <= StIdle;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            gch_ready    <= 1'b0;
            rcv0_ack_out <= 1'b0;
            rcv1_ack_out <= 1'b0;
            snd0_req_out <= 1'b0;
            snd0_data    <= '0;
            cnt0         <= '0;
            cnt1         <= '0;
        end else begin
            gch_ready <= 1'b1;
            unique case (state)
                StIdle: begin
                    if (gch_ready && (req0_sync || req1_sync)) begin
                        grant        <= pick1;
                        last_grant   <= pick1;
                        snd0_data    <= pick1 ? rcv1_data : rcv0_data;
                        snd0_req_out <= 1'b1;
                        state        <= StSend;
                    end
                end
                StSend: begin
                    if (ack_sync) begin
                        snd0_req_out <= 1'b0;
                        state        <= StDrain;
                    end
                end
                StDrain: begin
                    // Input is acked only after the sink has fully completed its handshake.
                    if (!ack_sync) begin
                        if (grant) begin
                            cnt1         <= cnt1 + 1'b1;
                            rcv1_ack_out <= 1'b1;
                        end else begin
                            cnt0         <= cnt0 + 1'b1;
                            rcv0_ack_out <= 1'b1;
                        end
                        state <= StRelease;
                    end
                end
                StRelease: begin
                    if (!granted_req) begin
                        rcv0_ack_out <= 1'b0;
                        rcv1_ack_out <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
